hx8352_init_seq: RTL and testbench

Initiator for the HX8352 panel power-up sequence, running in the 1 MHz control domain. It walks an external command ROM and executes one entry at a time. Command and data entries are issued to the LCD bus writer over a valid/ready handshake. Delay entries drive the microsecond delay timer's step/done interface, and control entries set the panel reset pin or end the sequence.

---
 rtl/hx8352_init_seq.sv | 168 ++++++++++++++++
 tb/tb_hx8352_init_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hx8352_init_seq.sv
// HX8352 power-up sequencer: walks a command ROM and issues each entry to the
// LCD bus writer, the microsecond delay timer, or the panel reset pin.
module hx8352_init_seq #(
   parameter int ROM_AW = 6
) (
   input  logic              clk_1MHz,
   input  logic              rst,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [17:0]       rom_data,
   output logic              wr_valid,
   output logic              wr_rs,
   output logic [15:0]       wr_data,
   input  logic              wr_ready,
   output logic              delay_step,
   output logic [15:0]       delay_us,
   input  logic              delay_done,
   output logic              lcd_rst_n,
   output logic              busy,
   output logic              init_done,
   output logic              err
);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, WRITE, STEP, GUARD, WAIT, DONE, ERR
   } state_t;

   localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

   state_t            state_reg, state_next;
   logic [ROM_AW-1:0] addr_reg, addr_next;
   logic              wr_valid_reg, wr_valid_next;
   logic              wr_rs_reg, wr_rs_next;
   logic [15:0]       wr_data_reg, wr_data_next;
   logic              step_reg, step_next;
   logic [15:0]       delay_us_reg, delay_us_next;
   logic              lcd_rst_n_reg, lcd_rst_n_next;
   logic              busy_reg, busy_next;
   logic              init_done_reg, init_done_next;
   logic              err_reg, err_next;
   logic              advance;

   logic [1:0]  op;
   logic [15:0] payload;
   assign op      = rom_data[17:16];
   assign payload = rom_data[15:0];

   always_ff @(posedge clk_1MHz or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         wr_valid_reg  <= 1'b0;
         wr_rs_reg     <= 1'b0;
         wr_data_reg   <= '0;
         step_reg      <= 1'b0;
         delay_us_reg  <= '0;
         lcd_rst_n_reg <= 1'b0;
         busy_reg      <= 1'b0;
         init_done_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         wr_valid_reg  <= wr_valid_next;
         wr_rs_reg     <= wr_rs_next;
         wr_data_reg   <= wr_data_next;
         step_reg      <= step_next;
         delay_us_reg  <= delay_us_next;
         lcd_rst_n_reg <= lcd_rst_n_next;
         busy_reg      <= busy_next;
         init_done_reg <= init_done_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      wr_valid_next  = wr_valid_reg;
      wr_rs_next     = wr_rs_reg;
      wr_data_next   = wr_data_reg;
      step_next      = step_reg;
      delay_us_next  = delay_us_reg;
      lcd_rst_n_next = lcd_rst_n_reg;
      busy_next      = busy_reg;
      init_done_next = init_done_reg;
      err_next       = err_reg;
      advance        = 1'b0;

      case (state_reg)
         IDLE, DONE, ERR: begin
            if (start) begin
               addr_next      = '0;
               busy_next      = 1'b1;
               init_done_next = 1'b0;
               err_next       = 1'b0;
               state_next     = FETCH;
            end
         end
         FETCH: state_next = DECODE;
         DECODE: begin
            case (op)
               2'b00, 2'b01: begin
                  wr_valid_next = 1'b1;
                  wr_rs_next    = op[0];
                  wr_data_next  = payload;
                  state_next    = WRITE;
               end
               2'b10: begin
                  delay_us_next = payload;
                  step_next     = 1'b1;
                  state_next    = STEP;
               end
               default: begin
                  if (payload[15]) begin
                     busy_next      = 1'b0;
                     init_done_next = 1'b1;
                     state_next     = DONE;
                  end else begin
                     lcd_rst_n_next = payload[0];
                     advance        = 1'b1;
                  end
               end
            endcase
         end
         WRITE: begin
            if (wr_ready) begin
               wr_valid_next = 1'b0;
               advance       = 1'b1;
            end
         end
         STEP: begin
            step_next  = 1'b0;
            state_next = GUARD;
         end
         // The timer only drops done after seeing the step, so skip one cycle.
         GUARD: state_next = WAIT;
         WAIT: begin
            if (delay_done) advance = 1'b1;
         end
         default: state_next = IDLE;
      endcase

      // Running off the end of the ROM is an error rather than a wrap.
      if (advance) begin
         if (addr_reg == LAST_ADDR) begin
            err_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = ERR;
         end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = FETCH;
         end
      end
   end

   assign rom_addr   = addr_reg;
   assign wr_valid   = wr_valid_reg;
   assign wr_rs      = wr_rs_reg;
   assign wr_data    = wr_data_reg;
   assign delay_step = step_reg;
   assign delay_us   = delay_us_reg;
   assign lcd_rst_n  = lcd_rst_n_reg;
   assign busy       = busy_reg;
   assign init_done  = init_done_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Directed bench for hx8352_init_seq with a behavioural ROM, bus writer
// and microsecond delay timer around the sequencer.
`timescale 1ns/1ps
module tb_hx8352_init_seq;

   localparam int AW = 3;

   logic          clk_1MHz = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [17:0]   rom_data;
   logic          wr_valid, wr_rs, wr_ready;
   logic [15:0]   wr_data;
   logic          delay_step, delay_done;
   logic [15:0]   delay_us;
   logic          lcd_rst_n, busy, init_done, err;

   int checks = 0;
   int errors = 0;

   logic [17:0] rom [8];
   logic [15:0] tmr_cnt;

   int          cyc = 0;
   int          start_cyc = 0;
   int          rise_cyc = 0;
   int          double_step = 0;
   logic        step_prev = 1'b0;
   logic        lcd_prev = 1'b0;
   logic [16:0] xfers [$];
   logic [15:0] steps [$];
   int          step_cyc [$];

   hx8352_init_seq #(.ROM_AW(AW)) dut (
      .clk_1MHz  (clk_1MHz),
      .rst       (rst),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .wr_valid  (wr_valid),
      .wr_rs     (wr_rs),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .delay_step(delay_step),
      .delay_us  (delay_us),
      .delay_done(delay_done),
      .lcd_rst_n (lcd_rst_n),
      .busy      (busy),
      .init_done (init_done),
      .err       (err)
   );

   always #500 clk_1MHz = ~clk_1MHz;

   always @(posedge clk_1MHz) rom_data <= rom[rom_addr];

   // Delay timer: done falls after a step, rises once the count has run out.
   always @(posedge clk_1MHz or posedge rst) begin
      if (rst) begin
         tmr_cnt    <= '0;
         delay_done <= 1'b1;
      end else if (delay_step) begin
         tmr_cnt    <= delay_us;
         delay_done <= 1'b0;
      end else if (!delay_done) begin
         if (tmr_cnt == 16'd0) delay_done <= 1'b1;
         else tmr_cnt <= tmr_cnt - 16'd1;
      end
   end

   always @(posedge clk_1MHz) begin
      cyc = cyc + 1;
      if (wr_valid && wr_ready) xfers.push_back({wr_rs, wr_data});
      if (delay_step) begin
         steps.push_back(delay_us);
         step_cyc.push_back(cyc);
         if (step_prev) double_step = double_step + 1;
      end
      step_prev = delay_step;
      if (lcd_rst_n && !lcd_prev) rise_cyc = cyc;
      lcd_prev = lcd_rst_n;
   end

   function automatic logic [17:0] ent(input logic [1:0] op, input logic [15:0] pl);
      return {op, pl};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_1MHz);
   endtask

   task automatic clear_all();
      for (int i = 0; i < 8; i++) rom[i] = ent(2'b11, 16'h8000);
      xfers.delete();
      steps.delete();
      step_cyc.delete();
      double_step = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_end(input int bound);
      int n = 0;
      while (!(init_done || err) && n < bound) begin
         tick(1);
         n++;
      end
      check("end_reached", {31'd0, init_done || err}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_wr_valid"}, wr_valid, 0);
      check({tag, "_wr_rs"}, wr_rs, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_delay_step"}, delay_step, 0);
      check({tag, "_delay_us"}, delay_us, 0);
      check({tag, "_lcd_rst_n"}, lcd_rst_n, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_init_done"}, init_done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      wr_ready = 1'b1;
      clear_all();
      tick(2);
      check_reset_outputs("rst");
      rst = 1'b0;
      tick(2);

      // CMD + DATA + END, writer always ready
      clear_all();
      rom[0] = ent(2'b00, 16'h0022);
      rom[1] = ent(2'b01, 16'h1234);
      rom[2] = ent(2'b11, 16'h8000);
      do_start();
      check("t1_busy", busy, 1);
      tick(7);
      check("t1_done_early", init_done, 0);
      tick(1);
      check("t1_done", init_done, 1);
      check("t1_busy_off", busy, 0);
      check("t1_nxfer", xfers.size(), 2);
      if (xfers.size() == 2) begin
         check("t1_x0", xfers[0], {1'b0, 16'h0022});
         check("t1_x1", xfers[1], {1'b1, 16'h1234});
      end
      $display("t1: cmd/data/end transfers=%0d init_done=%0b", xfers.size(), init_done);

      // Writer stalls 5 cycles on the CMD entry
      xfers.delete();
      wr_ready = 1'b0;
      do_start();
      tick(2);
      for (int i = 0; i < 6; i++) begin
         check("t2_hold_valid", wr_valid, 1);
         check("t2_hold_data", wr_data, 16'h0022);
         check("t2_hold_rs", wr_rs, 0);
         if (i < 5) tick(1);
      end
      wr_ready = 1'b1;
      wait_end(50);
      check("t2_nxfer", xfers.size(), 2);
      if (xfers.size() == 2) begin
         check("t2_x0", xfers[0], {1'b0, 16'h0022});
         check("t2_x1", xfers[1], {1'b1, 16'h1234});
      end
      $display("t2: stalled write transfers=%0d", xfers.size());

      // Panel reset pulse with delays
      clear_all();
      rom[0] = ent(2'b11, 16'h0000);
      rom[1] = ent(2'b10, 16'd10);
      rom[2] = ent(2'b11, 16'h0001);
      rom[3] = ent(2'b10, 16'd50);
      rom[4] = ent(2'b11, 16'h8000);
      do_start();
      wait_end(500);
      check("t3_lcd_rst_n", lcd_rst_n, 1);
      check("t3_low_ge10", {31'd0, (rise_cyc - start_cyc) >= 10}, 1);
      check("t3_nsteps", steps.size(), 2);
      check("t3_double", double_step, 0);
      if (steps.size() == 2) begin
         check("t3_us0", steps[0], 16'd10);
         check("t3_us1", steps[1], 16'd50);
         check("t3_wait_ge50", {31'd0, (cyc - step_cyc[1]) >= 50}, 1);
      end
      $display("t3: steps=%0d lcd_low_cycles=%0d", steps.size(), rise_cyc - start_cyc);

      // Zero-length delay
      clear_all();
      rom[0] = ent(2'b10, 16'd0);
      rom[1] = ent(2'b11, 16'h8000);
      do_start();
      wait_end(30);
      check("t4_done", init_done, 1);
      check("t4_nsteps", steps.size(), 1);
      $display("t4: delay 0 steps=%0d", steps.size());

      // No END entry: overrun
      clear_all();
      for (int i = 0; i < 8; i++) rom[i] = ent(2'b00, 16'h0100 + 16'(i));
      do_start();
      wait_end(200);
      check("t5_err", err, 1);
      check("t5_busy", busy, 0);
      check("t5_done", init_done, 0);
      check("t5_addr", rom_addr, 7);
      tick(5);
      check("t5_nxfer", xfers.size(), 8);
      check("t5_addr_hold", rom_addr, 7);
      if (xfers.size() == 8) check("t5_x7", xfers[7], {1'b0, 16'h0107});
      $display("t5: overrun transfers=%0d err=%0b", xfers.size(), err);

      // Reset during a long delay
      clear_all();
      rom[0] = ent(2'b10, 16'd1000);
      do_start();
      tick(15);
      check("t6_busy", busy, 1);
      check("t6_us", delay_us, 16'd1000);
      check("t6_lcd_pre", lcd_rst_n, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("t6");
      tick(1);
      rst = 1'b0;
      clear_all();
      rom[0] = ent(2'b00, 16'h0055);
      do_start();
      check("t6_restart_addr", rom_addr, 0);
      wait_end(50);
      check("t6_nxfer", xfers.size(), 1);
      if (xfers.size() == 1) check("t6_x0", xfers[0], {1'b0, 16'h0055});
      $display("t6: reset mid-delay, restart transfers=%0d", xfers.size());

      // start while busy is ignored; start after DONE reruns
      clear_all();
      rom[0] = ent(2'b00, 16'h0055);
      rom[1] = ent(2'b10, 16'd5);
      rom[2] = ent(2'b01, 16'h0066);
      do_start();
      tick(4);
      start = 1'b1;
      tick(3);
      start = 1'b0;
      wait_end(100);
      check("t7_nxfer", xfers.size(), 2);
      check("t7_nsteps", steps.size(), 1);
      if (xfers.size() == 2) check("t7_x1", xfers[1], {1'b1, 16'h0066});
      xfers.delete();
      do_start();
      check("t7_rerun_done_clr", init_done, 0);
      check("t7_rerun_busy", busy, 1);
      wait_end(100);
      check("t7_rerun_done", init_done, 1);
      check("t7_rerun_nxfer", xfers.size(), 2);
      $display("t7: rerun transfers=%0d init_done=%0b", xfers.size(), init_done);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
